sm4_stream_engine: RTL and testbench

// Parametrised, streaming SM4 block-cipher engine: successor to the single-shot encryptor.
// - One key/IV/mode configuration, then a packet of 1..N 128-bit blocks until last_i.
// - Modes: ECB, CBC and CTR; encrypt or decrypt.
// - UNROLL_P rounds are computed per cycle.
// - Sits between a DMA front-end (valid/ready) and a result sink (valid/yumi).

---
 rtl/sm4_encryptor_pkg.sv | 37 +++
 rtl/sm4_round_unit.sv | 26 ++
 rtl/sm4_stream_engine.sv | 149 ++++++++++++++
 tb/tb_sm4_stream_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm4_encryptor_pkg.sv
// rtl/sm4_encryptor_pkg.sv - SM4 constants, S-box/CK lookups and stream engine enums
package sm4_encryptor_pkg;
  localparam int group_size_p = 4;
  localparam int word_width_p = 32;

  localparam logic [127:0] key_xor_mask_p = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  // CK[0] sits in the most significant word
  localparam logic [1023:0] key_aux_p = {
    256'h00070e15_1c232a31_383f464d_545b6269_70777e85_8c939aa1_a8afb6bd_c4cbd2d9,
    256'he0e7eef5_fc030a11_181f262d_343b4249_50575e65_6c737a81_888f969d_a4abb2b9,
    256'hc0c7ced5_dce3eaf1_f8ff060d_141b2229_30373e45_4c535a61_686f767d_848b9299,
    256'ha0a7aeb5_bcc3cad1_d8dfe6ed_f4fb0209_10171e25_2c333a41_484f565d_646b7279
  };

  localparam logic [2047:0] sbox_table_p = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [1:0] {eEcb = 2'd0, eCbc = 2'd1, eCtr = 2'd2} mode_e;
  typedef enum logic [2:0] {eIdle, eKeyExp, eWait, eCrypt, eDone} stream_state_e;

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    return sbox_table_p[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] key_aux_f(input logic [4:0] i);
    return key_aux_p[1023 - 32*int'(i) -: 32];
  endfunction
endpackage

// File: rtl/sm4_round_unit.sv
// rtl/sm4_round_unit.sv - one combinational SM4 round, shared by key expansion and cipher
module sm4_round_unit
  import sm4_encryptor_pkg::*;
(
  input  logic [group_size_p*word_width_p-1:0] x,
  input  logic [word_width_p-1:0]              rk,
  input  logic                                 is_key,
  output logic [word_width_p-1:0]              y
);
  logic [31:0] t;
  logic [31:0] b;
  logic [31:0] l;

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  always_comb begin
    t = x[95:64] ^ x[63:32] ^ x[31:0] ^ rk;
    b = {sbox_f(t[31:24]), sbox_f(t[23:16]), sbox_f(t[15:8]), sbox_f(t[7:0])};
    // key schedule uses the lighter L' diffusion
    l = is_key ? (b ^ rol(b, 13) ^ rol(b, 23))
               : (b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24));
    y = x[127:96] ^ l;
  end
endmodule

// File: rtl/sm4_stream_engine.sv
// rtl/sm4_stream_engine.sv - streaming SM4 engine (ECB/CBC/CTR) with UNROLL_P rounds per cycle
module sm4_stream_engine
  import sm4_encryptor_pkg::*;
#(
  parameter int UNROLL_P    = 4,
  parameter int CTR_WIDTH_P = 32
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [127:0] cfg_key_i,
  input  logic [127:0] cfg_iv_i,
  input  logic [1:0]   cfg_mode_i,
  input  logic         cfg_decode_i,
  input  logic         cfg_v_i,
  output logic         cfg_ready_o,
  input  logic [127:0] data_i,
  input  logic         last_i,
  input  logic         v_i,
  output logic         ready_o,
  output logic [127:0] data_o,
  output logic         last_o,
  output logic         v_o,
  input  logic         yumi_i,
  output logic         busy_o
);
  localparam logic [4:0] step_lp     = 5'(UNROLL_P);
  localparam logic [4:0] last_cnt_lp = 5'(32 - UNROLL_P);

  stream_state_e state_q, state_n;
  mode_e         mode_q, cfg_mode;
  logic [4:0]    cnt_q;
  logic [127:0]  x_q, chain_q, mask_q;
  logic          dec_q, last_q;
  logic [31:0]   rk_q [32];
  logic [31:0]   word [UNROLL_P];
  logic [127:0]  x_next, result;
  logic          is_key;

  assign is_key = (state_q == eKeyExp);

  // The same round chain walks the key window during expansion and the data window afterwards
  for (genvar j = 0; j < UNROLL_P; j++) begin : g_round
    logic [4:0]   idx;
    logic [31:0]  rk;
    logic [127:0] x_in, x_out;
    if (j == 0) begin : g_first
      assign x_in = x_q;
    end else begin : g_next
      assign x_in = g_round[j-1].x_out;
    end
    assign idx = cnt_q + 5'(j);
    assign rk  = is_key ? key_aux_f(idx) : rk_q[dec_q ? ~idx : idx];
    sm4_round_unit u_round (.x(x_in), .rk(rk), .is_key(is_key), .y(word[j]));
    assign x_out = {x_in[95:0], word[j]};
  end

  assign x_next = g_round[UNROLL_P-1].x_out;
  assign result = {x_next[31:0], x_next[63:32], x_next[95:64], x_next[127:96]} ^ mask_q;

  always_comb begin
    cfg_mode = eEcb;
    case (cfg_mode_i)
      2'd1:    cfg_mode = eCbc;
      2'd2:    cfg_mode = eCtr;
      default: cfg_mode = eEcb;
    endcase
  end

  always_comb begin
    state_n     = state_q;
    cfg_ready_o = (state_q == eIdle);
    ready_o     = (state_q == eWait);
    v_o         = (state_q == eDone);
    busy_o      = (state_q != eIdle);
    case (state_q)
      eIdle:   if (cfg_v_i) state_n = eKeyExp;
      eKeyExp: if (cnt_q == last_cnt_lp) state_n = eWait;
      eWait:   if (v_i) state_n = eCrypt;
      eCrypt:  if (cnt_q == last_cnt_lp) state_n = eDone;
      eDone:   if (yumi_i) state_n = last_q ? eIdle : eWait;
      default: state_n = eIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      mode_q  <= eEcb;
      cnt_q   <= '0;
      x_q     <= '0;
      chain_q <= '0;
      mask_q  <= '0;
      dec_q   <= 1'b0;
      last_q  <= 1'b0;
      data_o  <= '0;
      last_o  <= 1'b0;
      for (int i = 0; i < 32; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_n;
      case (state_q)
        eIdle: if (cfg_v_i) begin
          x_q     <= cfg_key_i ^ key_xor_mask_p;
          chain_q <= cfg_iv_i;
          mode_q  <= cfg_mode;
          dec_q   <= cfg_decode_i && (cfg_mode != eCtr);
          cnt_q   <= '0;
        end
        eKeyExp: begin
          x_q   <= x_next;
          cnt_q <= cnt_q + step_lp;
          for (int j = 0; j < UNROLL_P; j++) rk_q[cnt_q + 5'(j)] <= word[j];
        end
        eWait: if (v_i) begin
          last_q <= last_i;
          cnt_q  <= '0;
          case (mode_q)
            eCbc: if (dec_q) begin
              x_q     <= data_i;
              mask_q  <= chain_q;
              chain_q <= data_i;
            end else begin
              x_q    <= data_i ^ chain_q;
              mask_q <= '0;
            end
            eCtr: begin
              x_q    <= chain_q;
              mask_q <= data_i;
              chain_q[CTR_WIDTH_P-1:0] <= chain_q[CTR_WIDTH_P-1:0] + CTR_WIDTH_P'(1);
            end
            default: begin
              x_q    <= data_i;
              mask_q <= '0;
            end
          endcase
        end
        eCrypt: begin
          x_q   <= x_next;
          cnt_q <= cnt_q + step_lp;
          if (cnt_q == last_cnt_lp) begin
            data_o <= result;
            last_o <= last_q;
            if (mode_q == eCbc && !dec_q) chain_q <= result;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sm4_stream_engine.sv
// tb/tb_sm4_stream_engine.sv - scoreboard bench for sm4_stream_engine at UNROLL_P 1, 4 and 8
module tb_sm4_stream_engine;
  localparam logic [127:0] K0 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C0 = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [2047:0] sbox_bits = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] cfg_key = '0, cfg_iv = '0, data_in = '0;
  logic [1:0]   cfg_mode = '0;
  logic         cfg_decode = 1'b0, last_in = 1'b0;
  logic         cfg_v [3] = '{1'b0, 1'b0, 1'b0};
  logic         v_in [3] = '{1'b0, 1'b0, 1'b0};
  logic         yumi [3] = '{1'b0, 1'b0, 1'b0};
  logic         cfg_ready [3], ready [3], last_out [3], v_out [3], busy [3];
  logic [127:0] data_out [3];

  int   checks = 0, errors = 0, cyc = 0, acc_cyc = 0, sel = 0;
  bit   hold = 1'b0, prev_v = 1'b0;
  exp_t exp_q [$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sm4_stream_engine #(.UNROLL_P((g == 0) ? 1 : (g == 1) ? 4 : 8), .CTR_WIDTH_P(32)) dut (
      .clk_i(clk), .reset_i(reset), .cfg_key_i(cfg_key), .cfg_iv_i(cfg_iv),
      .cfg_mode_i(cfg_mode), .cfg_decode_i(cfg_decode), .cfg_v_i(cfg_v[g]),
      .cfg_ready_o(cfg_ready[g]), .data_i(data_in), .last_i(last_in), .v_i(v_in[g]),
      .ready_o(ready[g]), .data_o(data_out[g]), .last_o(last_out[g]), .v_o(v_out[g]),
      .yumi_i(yumi[g]), .busy_o(busy[g]));
  end

  function automatic int unroll(input int s);
    return (s == 0) ? 1 : (s == 1) ? 4 : 8;
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_bits[2047 - 8*int'(a[8*i +: 8]) -: 8];
    return r;
  endfunction

  // Straight textbook SM4: full key schedule first, then 32 rounds
  function automatic logic [127:0] sm4_ref(input logic [127:0] key, input logic [127:0] blk,
                                           input bit dec);
    logic [31:0] k [36];
    logic [31:0] x [36];
    logic [31:0] ck, t, r;
    k[0] = key[127:96] ^ 32'ha3b1bac6;
    k[1] = key[95:64]  ^ 32'h56aa3350;
    k[2] = key[63:32]  ^ 32'h677d9197;
    k[3] = key[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ rl(t, 13) ^ rl(t, 23);
    end
    x[0] = blk[127:96]; x[1] = blk[95:64]; x[2] = blk[63:32]; x[3] = blk[31:0];
    for (int i = 0; i < 32; i++) begin
      r = dec ? k[35-i] : k[i+4];
      t = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ r);
      x[i+4] = x[i] ^ t ^ rl(t, 2) ^ rl(t, 10) ^ rl(t, 18) ^ rl(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: pops the scoreboard whenever the selected engine presents a result
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) yumi[i] = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (v_out[sel] && !prev_v)
        check("latency", 128'(cyc - acc_cyc), 128'(32 / unroll(sel)));
      prev_v = v_out[sel];
      if (v_out[sel] && !hold && !yumi[sel]) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_result");
        end else begin
          mon_e = exp_q.pop_front();
          check("data_o", data_out[sel], mon_e.d);
          check("last_o", 128'(last_out[sel]), 128'(mon_e.l));
        end
        yumi[sel] = 1'b1;
      end else begin
        yumi[sel] = 1'b0;
      end
    end
  end

  task automatic do_cfg(input int s, input logic [127:0] k, input logic [127:0] iv,
                        input logic [1:0] m, input logic d);
    int n = 0;
    while (cfg_ready[s] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) timeout("cfg_ready");
    cfg_key = k; cfg_iv = iv; cfg_mode = m; cfg_decode = d;
    cfg_v[s] = 1'b1;
    @(posedge clk); #1;
    cfg_v[s] = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input int s, input logic [127:0] d, input logic l,
                      input logic [127:0] e, input bit push);
    int n = 0;
    while (ready[s] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) timeout("ready_o");
    if (push) exp_q.push_back('{d: e, l: l});
    data_in = d; last_in = l; v_in[s] = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    v_in[s] = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || v_out[sel]) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) timeout("drain");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] pt [3];
    logic [127:0] ct [3];
    logic [127:0] iv, key1;
    pt[0] = K0;
    pt[1] = 128'h00112233445566778899aabbccddeeff;
    pt[2] = 128'hdeadbeef0badf00dcafebabe12345678;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_flags_u%0d", g),
            128'({cfg_ready[g], ready[g], v_out[g], last_out[g], busy[g]}), 128'(5'b10000));
      check($sformatf("reset_data_u%0d", g), data_out[g], '0);
    end
    reset = 1'b0;
    @(negedge clk);

    // ECB known answer at UNROLL_P=1 and 8
    sel = 0;
    do_cfg(0, K0, '0, 2'd0, 1'b0); send(0, K0, 1'b1, C0, 1'b1); drain();
    sel = 2;
    do_cfg(2, K0, '0, 2'd0, 1'b0); send(2, K0, 1'b1, C0, 1'b1); drain();
    do_cfg(2, K0, '0, 2'd0, 1'b1); send(2, C0, 1'b1, K0, 1'b1); drain();

    // UNROLL_P=4: ECB enc/dec and reserved mode 3 behaving as ECB
    sel = 1;
    do_cfg(1, K0, '0, 2'd0, 1'b0); send(1, K0, 1'b1, C0, 1'b1); drain();
    do_cfg(1, K0, '0, 2'd0, 1'b1); send(1, C0, 1'b1, K0, 1'b1); drain();
    do_cfg(1, K0, '0, 2'd3, 1'b0); send(1, K0, 1'b1, C0, 1'b1); drain();

    // CBC 3 blocks, IV=0: block0 equals the ECB answer
    ct[0] = C0;
    ct[1] = sm4_ref(K0, pt[1] ^ ct[0], 1'b0);
    ct[2] = sm4_ref(K0, pt[2] ^ ct[1], 1'b0);
    do_cfg(1, K0, '0, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) send(1, pt[i], (i == 2), ct[i], 1'b1);
    drain();
    do_cfg(1, K0, '0, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) send(1, ct[i], (i == 2), pt[i], 1'b1);
    drain();

    // CTR across the 32-bit counter wrap, then re-run (decode ignored) to restore
    key1 = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    iv   = 128'hfedcba98_76543210_00112233_ffffffff;
    ct[0] = pt[1] ^ sm4_ref(key1, iv, 1'b0);
    ct[1] = pt[2] ^ sm4_ref(key1, {iv[127:32], 32'h00000000}, 1'b0);
    do_cfg(1, key1, iv, 2'd2, 1'b0);
    send(1, pt[1], 1'b0, ct[0], 1'b1); send(1, pt[2], 1'b1, ct[1], 1'b1); drain();
    do_cfg(1, key1, iv, 2'd2, 1'b1);
    send(1, ct[0], 1'b0, pt[1], 1'b1); send(1, ct[1], 1'b1, pt[2], 1'b1); drain();

    // Backpressure with stray configuration pulses while busy
    do_cfg(1, K0, '0, 2'd0, 1'b0);
    hold = 1'b1;
    send(1, K0, 1'b0, C0, 1'b1);
    begin
      int n = 0;
      while (v_out[1] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) timeout("v_o_backpressure");
    end
    cfg_key = ~K0; cfg_mode = 2'd2;
    for (int i = 0; i < 20; i++) begin
      cfg_v[1] = (i % 2 == 0);
      @(negedge clk);
      check("hold_flags", 128'({v_out[1], ready[1], cfg_ready[1], busy[1]}), 128'(4'b1001));
      check("hold_data", data_out[1], C0);
    end
    cfg_v[1] = 1'b0;
    hold = 1'b0;
    send(1, K0, 1'b1, C0, 1'b1);
    drain();

    // Reset in the middle of eCrypt, then a fresh vector
    do_cfg(1, K0, '0, 2'd0, 1'b0);
    send(1, K0, 1'b1, C0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_flags", 128'({v_out[1], cfg_ready[1], busy[1], ready[1]}), 128'(4'b0100));
    check("abort_data", data_out[1], '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_cfg(1, K0, '0, 2'd0, 1'b0); send(1, K0, 1'b1, C0, 1'b1); drain();

    check("scoreboard_empty", 128'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
